// File: rtl/serial_addsub.sv
// Bit-serial adder, LSB first, one full-adder cell and a carry flop; WIDTH bit edges plus one DONE cycle.
// Define SERIAL_ADDSUB_SUB_EN to add the sub input (a-b, cout reports borrow).
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_inv;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;

  logic             w_sub;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res;

`ifdef SERIAL_ADDSUB_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_s   = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_c   = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
  assign w_res = {w_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_inv   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry.
            r_sa    <= a;
            r_sb    <= w_sub ? ~b : b;
            r_carry <= w_sub;
            r_inv   <= w_sub;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_res   <= w_res;
          r_carry <= w_c;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_sum   <= w_res;
            r_cout  <= w_c ^ r_inv;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub (WIDTH=8): cycle-level model of the handshake plus directed operations.
module tb_serial_addsub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDSUB_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: k = edges since the accepting edge (-1 when idle); result is plain arithmetic.
  int           k = -1;
  logic [W:0]   pend = '0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      k        = -1;
      exp_sum  = '0;
      exp_cout = 1'b0;
    end
    chk("m_ready", ready, (k < 0) ? 1 : 0);
    chk("m_busy",  busy,  (k >= 0 && k <= W-1) ? 1 : 0);
    chk("m_done",  done,  (k == W) ? 1 : 0);
    chk("m_sum",   sum,   exp_sum);
    chk("m_cout",  cout,  exp_cout);
    if (!rst) begin
      if (k < 0) begin
        if (start) begin
          k = 0;
`ifdef SERIAL_ADDSUB_SUB_EN
          if (sub) pend = {(a < b) ? 1'b1 : 1'b0, W'(a - b)};
          else     pend = {1'b0, a} + {1'b0, b};
`else
          pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, sub & 1'b0};
`endif
        end
      end else begin
        k = k + 1;
        if (k == W) begin
          exp_sum  = pend[W-1:0];
          exp_cout = pend[W];
        end else if (k == W + 1) begin
          k = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    a = ia; b = ib; sub = isub; start = 1'b1;
    tick();
    acc_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input logic [W-1:0] es, input logic ec);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    while (!seen && n < 3*W) begin
      @(negedge clk);
      n = n + 1;
      if (done === 1'b1) seen = 1;
    end
    chk({nm, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({nm, "_latency"}, cyc - acc_cyc, W);
      chk({nm, "_sum"}, sum, es);
      chk({nm, "_cout"}, cout, ec);
    end
    tick();
    chk({nm, "_ready_after"}, ready, 1);
  endtask

  int           done_cyc[$];
  logic [W-1:0] done_sum[$];
  int           ndone;

  initial begin
    rst = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_sum",   sum,   0);
    chk("rst_cout",  cout,  0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic add and ready recovery
    launch(8'd3, 8'd5, 1'b0);
    chk("s1_busy", busy, 1);
    wait_done("s1", 8'd8, 1'b0);

    // Overflow and zero cases
    launch(8'd255, 8'd1, 1'b0);   wait_done("s2a", 8'd0, 1'b1);
    launch(8'd200, 8'd100, 1'b0); wait_done("s2b", 8'd44, 1'b1);
    launch(8'd0, 8'd0, 1'b0);     wait_done("s2c", 8'd0, 1'b0);

    // start held high, operands change every cycle
    for (int i = 0; i < 30; i++) begin
      a = W'(10 + i); b = W'(3 * i); start = 1'b1;
      tick();
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        done_sum.push_back(sum);
      end
    end
    start = 1'b0;
    chk("s3_ndone", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk("s3_gap1", done_cyc[1] - done_cyc[0], W + 2);
      chk("s3_gap2", done_cyc[2] - done_cyc[1], W + 2);
      chk("s3_sum0", done_sum[0], 10);
      chk("s3_sum1", done_sum[1], 50);
      chk("s3_sum2", done_sum[2], 90);
    end
    tick();

    // Reset 4 cycles into RUN aborts with no done pulse
    launch(8'd77, 8'd11, 1'b0);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("s4_ready", ready, 1);
    chk("s4_busy",  busy,  0);
    chk("s4_sum",   sum,   0);
    chk("s4_cout",  cout,  0);
    tick(); tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) ndone = ndone + 1;
    end
    chk("s4_no_done", ndone, 0);
    launch(8'd10, 8'd20, 1'b0); wait_done("s4b", 8'd30, 1'b0);

    // start during RUN is ignored
    launch(8'd40, 8'd2, 1'b0);
    tick(); tick(); tick();
    a = 8'd100; b = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("s5", 8'd42, 1'b0);
    tick(); tick();
    chk("s5_idle", ready, 1);

`ifdef SERIAL_ADDSUB_SUB_EN
    launch(8'd5, 8'd3, 1'b1); wait_done("s6a", 8'd2, 1'b0);
    launch(8'd3, 8'd5, 1'b1); wait_done("s6b", 8'd254, 1'b1);
    launch(8'd3, 8'd5, 1'b0); wait_done("s6c", 8'd8, 1'b0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
